// File: rtl/trap_ctl_pkg.sv
// Shared definitions for the trap-entry / trap-return controller.
package trap_ctl_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int CAUSE_W = 6;

    typedef enum logic {
        TRAP_IDLE  = 1'b0,
        TRAP_REDIR = 1'b1
    } trap_state_t;

endpackage

// File: rtl/trap_ctl.sv
// Trap entry / xRET controller: owns trap CSRs and privilege, flushes the pipe and
// issues a PC redirect to fetch.
// Redirect handshake: redir_valid rises with redir_pc, both hold stable until a cycle
// with redir_valid && redir_ready; the transfer completes on that rising edge.
module trap_ctl
    import trap_ctl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_val,
    input  logic [XLEN-1:0] mem_pc,
    input  logic            mret,
    input  logic            sret,
    input  logic            stall_mem,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] medeleg,
    output logic [1:0]      priv,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic [XLEN-1:0] sepc,
    output logic [XLEN-1:0] scause,
    output logic [XLEN-1:0] stval,
    output logic            mstatus_mie,
    output logic            mstatus_mpie,
    output logic            mstatus_sie,
    output logic            mstatus_spie,
    output logic            mstatus_spp,
    output logic [1:0]      mstatus_mpp,
    output logic            t_flush,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            busy
);

    trap_state_t state;
    logic        to_s;
    logic        accept;

    // Vector mode bits are ignored: traps always land on the aligned BASE.
    logic [3:0] unused_vec_bits;
    assign unused_vec_bits = {mtvec[1:0], stvec[1:0]};

    assign to_s   = (priv != PRIV_M) && medeleg[exc_cause[CAUSE_W-1:0]];
    assign accept = (state == TRAP_IDLE) && !stall_mem && (exc || mret || sret);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TRAP_IDLE;
            busy         <= 1'b0;
            priv         <= PRIV_M;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            sepc         <= '0;
            scause       <= '0;
            stval        <= '0;
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_sie  <= 1'b0;
            mstatus_spie <= 1'b0;
            mstatus_spp  <= 1'b0;
            mstatus_mpp  <= 2'b00;
            t_flush      <= 1'b0;
            redir_valid  <= 1'b0;
            redir_pc     <= '0;
        end else begin
            t_flush <= 1'b0;
            case (state)
                TRAP_IDLE: begin
                    if (accept) begin
                        // Priority exc > mret > sret; the losers are simply dropped.
                        if (exc) begin
                            if (to_s) begin
                                sepc         <= mem_pc;
                                scause       <= exc_cause;
                                stval        <= exc_val;
                                mstatus_spie <= mstatus_sie;
                                mstatus_sie  <= 1'b0;
                                mstatus_spp  <= priv[0];
                                priv         <= PRIV_S;
                                redir_pc     <= {stvec[XLEN-1:2], 2'b00};
                            end else begin
                                mepc         <= mem_pc;
                                mcause       <= exc_cause;
                                mtval        <= exc_val;
                                mstatus_mpie <= mstatus_mie;
                                mstatus_mie  <= 1'b0;
                                mstatus_mpp  <= priv;
                                priv         <= PRIV_M;
                                redir_pc     <= {mtvec[XLEN-1:2], 2'b00};
                            end
                        end else if (mret) begin
                            priv         <= mstatus_mpp;
                            mstatus_mie  <= mstatus_mpie;
                            mstatus_mpie <= 1'b1;
                            mstatus_mpp  <= PRIV_U;
                            redir_pc     <= mepc;
                        end else begin
                            priv         <= {1'b0, mstatus_spp};
                            mstatus_sie  <= mstatus_spie;
                            mstatus_spie <= 1'b1;
                            mstatus_spp  <= 1'b0;
                            redir_pc     <= sepc;
                        end
                        t_flush     <= 1'b1;
                        redir_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= TRAP_REDIR;
                    end
                end
                TRAP_REDIR: begin
                    if (redir_valid && redir_ready) begin
                        redir_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= TRAP_IDLE;
                    end
                end
                default: begin
                    state <= TRAP_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
